// File: rtl/nes_test_top.sv
// Polls an NES pad and decodes the SNES PMOD stream into one active-high 12-button set.
// Outputs update one clock after either button register changes; SNES is preferred when both pads are present.
module nes_test_top #(
  parameter int POLL_CYCLES    = 416667,
  parameter int LATCH_CYCLES   = 300,
  parameter int HALF_CYCLES    = 150,
  parameter int PMOD_BITS      = 24,
  parameter int TIMEOUT_CYCLES = 833334
) (
  input  logic system_clk_25MHz,
  input  logic rst_n,
  input  logic NES_Data,
  output logic NES_Latch,
  output logic NES_Clk,
  input  logic SNES_PMOD_Data,
  input  logic SNES_PMOD_Clk,
  input  logic SNES_PMOD_Latch,
  output logic A_out,
  output logic B_out,
  output logic select_out,
  output logic start_out,
  output logic up_out,
  output logic down_out,
  output logic left_out,
  output logic right_out,
  output logic X_out,
  output logic Y_out,
  output logic L_out,
  output logic R_out,
  output logic controller_status
);

  localparam int PW  = $clog2(POLL_CYCLES);
  localparam int PHM = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int HW  = $clog2(PHM) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(LATCH_CYCLES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_DONE
  } nes_st_e;

  nes_st_e       st_q, st_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [HW-1:0] ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    nsh_q, nsh_d;
  logic [7:0]    nbtn_q, nbtn_d;
  logic          first_q, first_d;
  logic          nlatch_q, nclk_q;

  always_comb begin
    st_d    = st_q;
    poll_d  = (poll_q == POLL_LAST) ? poll_q : poll_q + PW'(1);
    ph_d    = ph_q + HW'(1);
    bit_d   = bit_q;
    nsh_d   = nsh_q;
    nbtn_d  = nbtn_q;
    first_d = first_q;
    case (st_q)
      ST_IDLE: begin
        ph_d = '0;
        if (first_q || (poll_q == POLL_LAST)) begin
          st_d    = ST_LATCH;
          poll_d  = '0;
          first_d = 1'b0;
          bit_d   = '0;
          nsh_d   = '0;
        end
      end
      ST_LATCH: begin
        if (ph_q == LATCH_LAST) begin
          nsh_d[0] = ~NES_Data;
          st_d     = ST_CLK_HI;
          ph_d     = '0;
        end
      end
      ST_CLK_HI: begin
        if (ph_q == HALF_LAST) begin
          st_d = ST_CLK_LO;
          ph_d = '0;
        end
      end
      ST_CLK_LO: begin
        if (ph_q == HALF_LAST) begin
          ph_d = '0;
          // The read after the eighth pulse carries no button and is dropped.
          if (bit_q == 3'd7) begin
            st_d = ST_DONE;
          end else begin
            nsh_d[bit_q + 3'd1] = ~NES_Data;
            bit_d               = bit_q + 3'd1;
            st_d                = ST_CLK_HI;
          end
        end
      end
      ST_DONE: begin
        st_d   = ST_IDLE;
        ph_d   = '0;
        nbtn_d = (&nsh_q) ? 8'h00 : nsh_q;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      poll_q   <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      nsh_q    <= '0;
      nbtn_q   <= '0;
      first_q  <= 1'b1;
      nlatch_q <= 1'b0;
      nclk_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      poll_q   <= poll_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      nsh_q    <= nsh_d;
      nbtn_q   <= nbtn_d;
      first_q  <= first_d;
      nlatch_q <= (st_d == ST_LATCH);
      nclk_q   <= (st_d == ST_CLK_HI);
    end
  end

  assign NES_Latch = nlatch_q;
  assign NES_Clk   = nclk_q;

  // Clk and Latch keep a third stage for edge detection; data only needs two.
  logic [2:0]           pclk_q, plat_q;
  logic [1:0]           pdat_q;
  logic [PMOD_BITS-1:0] psh_q, psh_d;
  logic [11:0]          sbtn_q, sbtn_d;
  logic                 svalid_q, svalid_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 clk_rise, lat_rise;
  logic [11:0]          field, field_canon;

  assign clk_rise = pclk_q[1] & ~pclk_q[2];
  assign lat_rise = plat_q[1] & ~plat_q[2];
  assign field    = psh_q[PMOD_BITS-1 -: 12];
  // field[11] is the first bit shifted in (B); reorder to {R,L,Y,X,Rt,Lt,Dn,Up,St,Sel,B,A}.
  assign field_canon = {field[0], field[1], field[10], field[2], field[4], field[5],
                        field[6], field[7], field[8], field[9], field[11], field[3]};

  always_comb begin
    psh_d    = psh_q;
    sbtn_d   = sbtn_q;
    svalid_d = svalid_q;
    to_d     = to_q;
    if (lat_rise) begin
      psh_d    = '0;
      to_d     = '0;
      svalid_d = ~&field;
      sbtn_d   = (&field) ? 12'h000 : field_canon;
    end else begin
      if (clk_rise) begin
        psh_d = {psh_q[PMOD_BITS-2:0], ~pdat_q[1]};
      end
      if (svalid_q) begin
        if (to_q == TO_LAST) begin
          svalid_d = 1'b0;
          sbtn_d   = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
    end
  end

  logic [11:0] out_q;
  logic        stat_q;

  always_ff @(posedge system_clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q   <= '0;
      plat_q   <= '0;
      pdat_q   <= '0;
      psh_q    <= '0;
      sbtn_q   <= '0;
      svalid_q <= 1'b0;
      to_q     <= '0;
      out_q    <= '0;
      stat_q   <= 1'b0;
    end else begin
      pclk_q   <= {pclk_q[1:0], SNES_PMOD_Clk};
      plat_q   <= {plat_q[1:0], SNES_PMOD_Latch};
      pdat_q   <= {pdat_q[0], SNES_PMOD_Data};
      psh_q    <= psh_d;
      sbtn_q   <= sbtn_d;
      svalid_q <= svalid_d;
      to_q     <= to_d;
      out_q    <= svalid_q ? sbtn_q : {4'b0000, nbtn_q};
      stat_q   <= svalid_q;
    end
  end

  assign A_out             = out_q[0];
  assign B_out             = out_q[1];
  assign select_out        = out_q[2];
  assign start_out         = out_q[3];
  assign up_out            = out_q[4];
  assign down_out          = out_q[5];
  assign left_out          = out_q[6];
  assign right_out         = out_q[7];
  assign X_out             = out_q[8];
  assign Y_out             = out_q[9];
  assign L_out             = out_q[10];
  assign R_out             = out_q[11];
  assign controller_status = stat_q;

endmodule

// File: tb/tb_nes_test_top.sv
// Bench for nes_test_top: NES pad responder, PMOD frame driver and an expected-output queue.
module tb_nes_test_top;
  localparam int POLL = 2000;
  localparam int LAT  = 30;
  localparam int HALF = 15;
  localparam int TO   = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic NES_Data, NES_Latch, NES_Clk;
  logic SNES_PMOD_Data = 1'b0, SNES_PMOD_Clk = 1'b0, SNES_PMOD_Latch = 1'b0;
  logic A_out, B_out, select_out, start_out, up_out, down_out, left_out, right_out;
  logic X_out, Y_out, L_out, R_out, controller_status;

  always #20 clk = ~clk;

  nes_test_top #(
    .POLL_CYCLES(POLL), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF),
    .PMOD_BITS(24), .TIMEOUT_CYCLES(TO)
  ) dut (
    .system_clk_25MHz(clk), .rst_n(rst_n),
    .NES_Data(NES_Data), .NES_Latch(NES_Latch), .NES_Clk(NES_Clk),
    .SNES_PMOD_Data(SNES_PMOD_Data), .SNES_PMOD_Clk(SNES_PMOD_Clk),
    .SNES_PMOD_Latch(SNES_PMOD_Latch),
    .A_out(A_out), .B_out(B_out), .select_out(select_out), .start_out(start_out),
    .up_out(up_out), .down_out(down_out), .left_out(left_out), .right_out(right_out),
    .X_out(X_out), .Y_out(Y_out), .L_out(L_out), .R_out(R_out),
    .controller_status(controller_status)
  );

  // NES pad model: latch presents A, each clock rising edge advances one button.
  logic [7:0] nes_raw = 8'hFF;
  int nes_idx = 8;
  always @(posedge NES_Latch or posedge NES_Clk) begin
    if (NES_Latch) nes_idx = 0;
    else nes_idx = nes_idx + 1;
  end
  assign NES_Data = (nes_idx < 8) ? nes_raw[nes_idx[2:0]] : 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {controller_status, R_out, L_out, Y_out, X_out, right_out, left_out,
            down_out, up_out, start_out, select_out, B_out, A_out};
  endfunction

  function automatic logic sig(input int sel);
    if (sel == 0) return NES_Latch;
    if (sel == 1) return NES_Clk;
    return controller_status;
  endfunction

  task automatic pop_cmp(input string tag);
    logic [12:0] e;
    chk({tag, "_qdepth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(outs()), 32'(e));
    end
  endtask

  // Counts falling edges until the selected signal reaches lvl, giving up after budget.
  task automatic wait_level(input int sel, input logic lvl, input int budget, output int n);
    n = 0;
    while (sig(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Entered at the first falling edge that sees NES_Latch high.
  task automatic measure_frame(input string tag, input bit full);
    int n;
    wait_level(0, 1'b0, LAT * 4, n);
    chk({tag, "_latch_w"}, 32'(n), 32'(LAT));
    for (int p = 0; p < 8; p++) begin
      wait_level(1, 1'b0, HALF * 4, n);
      chk($sformatf("%s_hi%0d", tag, p), 32'(n), 32'(HALF));
      if (!full) return;
      if (p < 7) begin
        wait_level(1, 1'b1, HALF * 4, n);
        chk($sformatf("%s_lo%0d", tag, p), 32'(n), 32'(HALF));
      end
    end
    wait_level(1, 1'b1, 20, n);
    chk({tag, "_no_9th_pulse"}, 32'(n), 32'd20);
    pop_cmp({tag, "_out"});
  endtask

  task automatic send_pmod(input logic [23:0] frame, input bit do_chk, input string tag);
    for (int i = 23; i >= 0; i--) begin
      SNES_PMOD_Data = frame[i];
      repeat (3) @(negedge clk);
      SNES_PMOD_Clk = 1'b1;
      repeat (3) @(negedge clk);
      SNES_PMOD_Clk = 1'b0;
      repeat (3) @(negedge clk);
    end
    SNES_PMOD_Latch = 1'b1;
    repeat (4) @(negedge clk);
    if (do_chk) pop_cmp(tag);
    SNES_PMOD_Latch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    // Reset with noisy inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      SNES_PMOD_Data  = 1'($urandom_range(0, 1));
      SNES_PMOD_Clk   = 1'($urandom_range(0, 1));
      SNES_PMOD_Latch = 1'($urandom_range(0, 1));
      nes_raw         = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_latch", 32'(NES_Latch), 32'd0);
    chk("rst_clk", 32'(NES_Clk), 32'd0);
    exp_q.push_back(13'h0000);
    pop_cmp("rst_out");
    SNES_PMOD_Data = 1'b0; SNES_PMOD_Clk = 1'b0; SNES_PMOD_Latch = 1'b0;
    nes_raw = 8'h5A;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("latch_rise", 32'(NES_Latch), 32'd1);
    t0 = cyc;

    // NES frame: A, Select, Down, Right pressed
    exp_q.push_back({1'b0, 12'h0A5});
    measure_frame("nes1", 1'b1);

    // NES absent: line held low
    nes_raw = 8'h00;
    exp_q.push_back(13'h0000);
    wait_level(0, 1'b1, POLL + 100, n);
    chk("poll_period", 32'(cyc - t0), 32'(POLL));
    measure_frame("nes_absent", 1'b1);

    // SNES frame: B, Start, A, R pressed
    exp_q.push_back({1'b1, 12'h80B});
    send_pmod(24'h6F6FFF, 1'b1, "snes1");

    // SNES X+L over NES Up, then timeout reveals NES
    nes_raw = 8'hEF;
    for (int f = 0; f < 13; f++) send_pmod(24'hFF9FFF, 1'b0, "");
    exp_q.push_back({1'b1, 12'h500});
    send_pmod(24'hFF9FFF, 1'b1, "snes_prio");
    repeat (TO - 20) @(negedge clk);
    chk("alive_before_to", 32'(controller_status), 32'd1);
    wait_level(2, 1'b0, 100, n);
    chk("to_window", 32'(n >= 10 && n <= 22), 32'd1);
    exp_q.push_back({1'b0, 12'h010});
    pop_cmp("to_nes_up");

    // SNES frame with every button pressed counts as absent
    exp_q.push_back({1'b0, 12'h010});
    send_pmod(24'h000000, 1'b1, "snes_allp");

    // Reset during a clock-high phase
    wait_level(1, 1'b1, POLL + 500, n);
    chk("found_clk_hi", 32'(NES_Clk), 32'd1);
    repeat (5) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("rst_mid_clk", 32'(NES_Clk), 32'd0);
    chk("rst_mid_latch", 32'(NES_Latch), 32'd0);
    exp_q.push_back(13'h0000);
    pop_cmp("rst_mid_out");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("latch_rise2", 32'(NES_Latch), 32'd1);
    measure_frame("nes_after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
